// File: rtl/audio_pkg.sv
// audio_pkg: constants and helpers shared by the IEC 60958 audio sample packetizer.
package audio_pkg;
    localparam logic [7:0] AUDIO_SAMPLE_HB0 = 8'h02;
    localparam int CS_BITS = 192;
    typedef logic [55:0] subpacket_t;
    // Consumer channel status; copyright bit set means "not asserted".
    function automatic logic [CS_BITS-1:0] cs_word(
        input logic [3:0] chan_num,
        input logic [3:0] sf,
        input logic [3:0] wl
    );
        logic [CS_BITS-1:0] w;
        w = '0;
        w[2] = 1'b1;
        w[23:20] = chan_num;
        w[27:24] = sf;
        w[35:32] = wl;
        return w;
    endfunction
    function automatic logic even_parity(input logic [26:0] d);
        return ^d;
    endfunction
    function automatic logic [7:0] fc_add(input logic [7:0] base, input logic [2:0] k);
        logic [8:0] s;
        s = {1'b0, base} + {6'd0, k};
        return (s >= 9'd192) ? 8'(s - 9'd192) : s[7:0];
    endfunction
endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: frame FIFO, first-word-fall-through with a 4-entry lookahead read.
module audio_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk_pixel,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic [2:0]                 pop_cnt,
    output logic [3:0][WIDTH-1:0]      rd_data,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk_pixel)
        if (push) mem[wr_ptr] <= wr_data;
    always_ff @(posedge clk_pixel or negedge reset_n)
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop_cnt);
            level <= level + (AW+1)'(push) - (AW+1)'(pop_cnt);
        end
    always_comb
        for (int k = 0; k < 4; k++) rd_data[k] = mem[rd_ptr + AW'(k)];
endmodule

// File: rtl/audio_sample_packetizer.sv
// audio_sample_packetizer: packs buffered PCM frames into HDMI audio sample packets,
// one packet per accepted data-island request.
module audio_sample_packetizer
    import audio_pkg::*;
#(
    parameter int         CHANNEL_COUNT      = 2,
    parameter int         SAMPLE_WIDTH       = 16,
    parameter int         FIFO_DEPTH         = 8,
    parameter logic [3:0] SAMPLING_FREQUENCY = 4'b0000,
    parameter logic [3:0] WORD_LENGTH        = 4'b0010
) (
    input  logic                                        clk_pixel,
    input  logic                                        reset_n,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [CHANNEL_COUNT-1:0][SAMPLE_WIDTH-1:0]  in_sample,
    input  logic                                        pkt_request,
    output logic                                        pkt_valid,
    output logic [23:0]                                 header,
    output logic [3:0][55:0]                            sub,
    output logic [$clog2(FIFO_DEPTH):0]                 fifo_level
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = SAMPLE_WIDTH;
    localparam int FW = CHANNEL_COUNT * SAMPLE_WIDTH;
    localparam logic LAYOUT = 1'(CHANNEL_COUNT > 2);

    logic ready_en, accept;
    logic [2:0] pop_cnt;
    logic [3:0][FW-1:0] rd_data;
    logic [7:0] frame_cnt;
    logic [3:0] present, b_bits;
    logic [3:0][55:0] nxt_sub;

    function automatic subpacket_t make_sub(
        input logic [SW-1:0] l,
        input logic [SW-1:0] r,
        input int            lch,
        input logic [7:0]    fc
    );
        logic [CS_BITS-1:0] cs_l, cs_r;
        logic [23:0] w_l, w_r;
        logic c_l, c_r;
        cs_l = cs_word(4'(lch + 1), SAMPLING_FREQUENCY, WORD_LENGTH);
        cs_r = cs_word(4'(lch + 2), SAMPLING_FREQUENCY, WORD_LENGTH);
        c_l = cs_l[fc];
        c_r = cs_r[fc];
        w_l = 24'(l) << (24 - SW);
        w_r = 24'(r) << (24 - SW);
        return {even_parity({c_r, 2'b00, w_r}), c_r, 2'b00,
                even_parity({c_l, 2'b00, w_l}), c_l, 2'b00, w_r, w_l};
    endfunction

    assign in_ready = ready_en && (fifo_level < LW'(FIFO_DEPTH));
    assign accept = pkt_request && !pkt_valid && (fifo_level != '0);
    assign pop_cnt = !accept ? 3'd0 : LAYOUT ? 3'd1 :
                     (fifo_level >= LW'(4)) ? 3'd4 : 3'(fifo_level);

    audio_sample_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .push      (in_valid && in_ready),
        .wr_data   (in_sample),
        .pop_cnt   (pop_cnt),
        .rd_data   (rd_data),
        .level     (fifo_level)
    );

    // Stereo spreads up to four frames over the subpackets; multichannel uses one frame.
    always_comb begin
        nxt_sub = '0;
        present = '0;
        b_bits = '0;
        if (!LAYOUT) begin
            for (int k = 0; k < 4; k++)
                if (k < int'(fifo_level)) begin
                    present[k] = 1'b1;
                    b_bits[k] = fc_add(frame_cnt, 3'(k)) == 8'd0;
                    nxt_sub[k] = make_sub(rd_data[k][0 +: SW], rd_data[k][SW +: SW], 0,
                                          fc_add(frame_cnt, 3'(k)));
                end
        end else begin
            b_bits[0] = frame_cnt == 8'd0;
            for (int i = 0; i < CHANNEL_COUNT / 2; i++) begin
                present[i] = 1'b1;
                nxt_sub[i] = make_sub(rd_data[0][2*i*SW +: SW], rd_data[0][(2*i+1)*SW +: SW],
                                      2 * i, frame_cnt);
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n)
        if (!reset_n) begin
            ready_en <= 1'b0;
            pkt_valid <= 1'b0;
            frame_cnt <= '0;
            header <= '0;
            sub <= '0;
        end else begin
            ready_en <= 1'b1;
            pkt_valid <= accept;
            if (accept) begin
                header <= {b_bits, 4'b0000, 3'b000, LAYOUT, present, AUDIO_SAMPLE_HB0};
                sub <= nxt_sub;
                frame_cnt <= fc_add(frame_cnt, pop_cnt);
            end
        end
endmodule

// File: tb/tb_audio_sample_packetizer.sv
// tb_audio_sample_packetizer: directed checks of a stereo and an 8-channel packetizer.
module tb_audio_sample_packetizer;
    logic clk_pixel = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk_pixel = ~clk_pixel;

    int n_cmp = 0;
    int n_bad = 0;

    logic s_valid = 1'b0, s_req = 1'b0, s_ready, s_pkt_valid;
    logic [1:0][15:0] s_sample = '0;
    logic [23:0] s_header;
    logic [3:0][55:0] s_sub;
    logic [3:0] s_level;

    logic m_valid = 1'b0, m_req = 1'b0, m_ready, m_pkt_valid;
    logic [7:0][15:0] m_sample = '0;
    logic [23:0] m_header;
    logic [3:0][55:0] m_sub;
    logic [2:0] m_level;

    audio_sample_packetizer #(.CHANNEL_COUNT(2), .SAMPLE_WIDTH(16), .FIFO_DEPTH(8)) dut_s (
        .clk_pixel (clk_pixel), .reset_n (reset_n), .in_valid (s_valid), .in_ready (s_ready),
        .in_sample (s_sample), .pkt_request (s_req), .pkt_valid (s_pkt_valid),
        .header (s_header), .sub (s_sub), .fifo_level (s_level)
    );

    audio_sample_packetizer #(.CHANNEL_COUNT(8), .SAMPLE_WIDTH(16), .FIFO_DEPTH(4)) dut_m (
        .clk_pixel (clk_pixel), .reset_n (reset_n), .in_valid (m_valid), .in_ready (m_ready),
        .in_sample (m_sample), .pkt_request (m_req), .pkt_valid (m_pkt_valid),
        .header (m_header), .sub (m_sub), .fifo_level (m_level)
    );

    typedef struct {
        int n;
        logic [15:0] l;
        logic [15:0] r;
        logic [7:0] hb1;
        logic [7:0] hb2;
        logic [55:0] sub0;
        logic [55:0] sub3;
    } vec_t;
    vec_t vecs [4];

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push_s(input logic [15:0] l, input logic [15:0] r);
        s_valid = 1'b1;
        s_sample = {r, l};
        tick();
        s_valid = 1'b0;
    endtask

    task automatic req_s();
        s_req = 1'b1;
        tick();
        s_req = 1'b0;
    endtask

    task automatic set_m(input int f);
        for (int c = 0; c < 8; c++) m_sample[c] = 16'(f * 16 + c);
    endtask

    // Set bits of the consumer status word: copyright(2), channel number(20..), word length(33).
    function automatic logic exp_c(input int ch, input int fc);
        return fc == 2 || fc == 33 || fc == 19 + ch;
    endfunction

    initial begin
        int cnt;
        logic [7:0] hb2;
        logic [15:0] lv;
        logic cl;
        vecs[0] = '{2, 16'h1234, 16'hABCD, 8'h03, 8'h10, 56'h08_ABCD00_123400, 56'h0};
        vecs[1] = '{4, 16'h0000, 16'h0001, 8'h0F, 8'h00, 56'h4C_000100_000000, 56'h80_000400_000300};
        vecs[2] = '{1, 16'hFFFF, 16'h8000, 8'h01, 8'h00, 56'h80_800000_FFFF00, 56'h0};
        vecs[3] = '{3, 16'h0F0F, 16'h0001, 8'h07, 8'h00, 56'h80_000100_0F0F00, 56'h0};

        #1 reset_n = 1'b0;
        #2;
        chk("rst_ready", s_ready, 0);
        chk("rst_pkt_valid", s_pkt_valid, 0);
        chk("rst_level", s_level, 0);
        chk("rst_header", s_header, 0);
        @(posedge clk_pixel);
        #1;
        chk("rst_ready_held", {s_ready, m_ready}, 0);
        @(negedge clk_pixel);
        reset_n = 1'b1;
        tick();
        chk("ready_after_rst", {s_ready, m_ready}, 2'b11);

        for (int v = 0; v < 4; v++) begin
            for (int j = 0; j < vecs[v].n; j++)
                push_s(vecs[v].l + 16'(j), vecs[v].r + 16'(j));
            chk($sformatf("vec%0d_level_pre", v), s_level, vecs[v].n);
            req_s();
            chk($sformatf("vec%0d_valid", v), s_pkt_valid, 1);
            chk($sformatf("vec%0d_header", v), s_header, {vecs[v].hb2, vecs[v].hb1, 8'h02});
            chk($sformatf("vec%0d_sub0", v), s_sub[0], vecs[v].sub0);
            chk($sformatf("vec%0d_sub3", v), s_sub[3], vecs[v].sub3);
            chk($sformatf("vec%0d_level", v), s_level, 0);
            tick();
            chk($sformatf("vec%0d_valid_drop", v), s_pkt_valid, 0);
        end

        req_s();
        chk("empty_valid", s_pkt_valid, 0);
        tick();
        chk("empty_valid2", s_pkt_valid, 0);
        chk("empty_level", s_level, 0);
        push_s(16'h0000, 16'h0000);
        req_s();
        chk("after_empty_header", s_header, {8'h00, 8'h01, 8'h02});
        chk("after_empty_sub0", s_sub[0], 56'h0);
        tick();

        push_s(16'h0003, 16'h0000);
        s_valid = 1'b1;
        s_sample = {16'h0000, 16'h0001};
        s_req = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("simul_valid", s_pkt_valid, 1);
        chk("simul_header", s_header, {8'h00, 8'h01, 8'h02});
        chk("simul_sub0", s_sub[0], 56'h00_000000_000300);
        chk("simul_level", s_level, 1);
        tick();
        s_req = 1'b0;
        chk("req_during_valid_ignored", s_pkt_valid, 0);
        chk("req_during_valid_level", s_level, 1);
        req_s();
        chk("simul_next_header", s_header, {8'h00, 8'h01, 8'h02});
        chk("simul_next_sub0", s_sub[0], 56'h08_000000_000100);
        chk("simul_next_level", s_level, 0);
        tick();

        cnt = 13;
        for (int p = 0; p < 48; p++) begin
            for (int k = 0; k < 4; k++) push_s(16'(p * 4 + k + 1), 16'(p));
            req_s();
            hb2 = '0;
            for (int k = 0; k < 4; k++) if ((cnt + k) % 192 == 0) hb2[4 + k] = 1'b1;
            chk($sformatf("wrap%0d_header", p), s_header, {hb2, 8'h0F, 8'h02});
            for (int k = 0; k < 4; k++) begin
                lv = 16'(p * 4 + k + 1);
                cl = exp_c(1, (cnt + k) % 192);
                chk($sformatf("wrap%0d_c_l%0d", p, k), s_sub[k][50], cl);
                chk($sformatf("wrap%0d_c_r%0d", p, k), s_sub[k][54], exp_c(2, (cnt + k) % 192));
                chk($sformatf("wrap%0d_p_l%0d", p, k), s_sub[k][51], ^{cl, lv});
                chk($sformatf("wrap%0d_word_l%0d", p, k), s_sub[k][23:0], {lv, 8'h00});
                chk($sformatf("wrap%0d_word_r%0d", p, k), s_sub[k][47:24], {16'(p), 8'h00});
            end
            cnt = (cnt + 4) % 192;
            tick();
        end

        for (int f = 0; f < 4; f++) begin
            m_valid = 1'b1;
            set_m(f);
            tick();
        end
        chk("m_full_level", m_level, 4);
        chk("m_full_ready", m_ready, 0);
        set_m(4);
        tick();
        tick();
        chk("m_fifth_held_level", m_level, 4);
        chk("m_fifth_held_ready", m_ready, 0);
        m_req = 1'b1;
        tick();
        m_req = 1'b0;
        chk("m_valid", m_pkt_valid, 1);
        chk("m_header0", m_header, {8'h10, 8'h1F, 8'h02});
        chk("m_sub0", m_sub[0], 56'h80_000100_000000);
        chk("m_sub3", m_sub[3], 56'h80_000700_000600);
        chk("m_level_pop", m_level, 3);
        chk("m_ready_pop", m_ready, 1);
        tick();
        m_valid = 1'b0;
        chk("m_fifth_pushed", m_level, 4);
        chk("m_valid_drop", m_pkt_valid, 0);
        for (int f = 1; f < 5; f++) begin
            m_req = 1'b1;
            tick();
            m_req = 1'b0;
            chk($sformatf("m_header%0d", f), m_header, {8'h00, 8'h1F, 8'h02});
            chk($sformatf("m_sub0_words%0d", f), m_sub[0][47:0],
                {16'(f * 16 + 1), 8'h00, 16'(f * 16), 8'h00});
            tick();
        end
        chk("m_drained", m_level, 0);
        chk("m_drained_ready", m_ready, 1);

        push_s(16'h1111, 16'h2222);
        push_s(16'h3333, 16'h4444);
        req_s();
        chk("rstpkt_valid", s_pkt_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("rstpkt_valid_cleared", s_pkt_valid, 0);
        chk("rstpkt_header", s_header, 0);
        chk("rstpkt_sub", |s_sub, 0);
        chk("rstpkt_ready", s_ready, 0);
        chk("rstpkt_level", s_level, 0);
        @(negedge clk_pixel);
        reset_n = 1'b1;
        tick();
        chk("rel_ready", s_ready, 1);
        chk("rel_level", s_level, 0);
        push_s(16'h0001, 16'h0000);
        req_s();
        chk("rel_header", s_header, {8'h10, 8'h01, 8'h02});
        chk("rel_sub0", s_sub[0], 56'h08_000000_000100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/audio_sample_packetizer.md
AUDIO_SAMPLE_PACKETIZER -- requirements
Module: audio_sample_packetizer

Interface
REQ-001 SHALL have parameter CHANNEL_COUNT, default 2, meaning the audio channels per sample frame (even, 2..8).
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 16, meaning the bits per sample (16..24), MSB-aligned into the 24-bit IEC word with zero LSB fill.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning the sample frames buffered (power of 2, 4..32).
REQ-004 SHALL have parameters SAMPLING_FREQUENCY (4'b0000) and WORD_LENGTH (4'b0010), meaning the IEC 60958-3 channel-status fields; all other status bits are 0 except copyright-not-asserted = 1.
REQ-005 SHALL have port clk_pixel  input  1  sole clock.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_valid  input  1  sample frame offered.
REQ-008 SHALL have port in_ready  output  1  FIFO not full.
REQ-009 SHALL have port in_sample  input  CHANNEL_COUNT x SAMPLE_WIDTH  channel n = element n.
REQ-010 SHALL have port pkt_request  input  1  one-cycle pulse: data-island slot available.
REQ-011 SHALL have port pkt_valid  output  1  header/sub hold a packet this cycle.
REQ-012 SHALL have port header  output  24  {HB2, HB1, HB0}.
REQ-013 SHALL have port sub  output  4 x 56  subpackets 0..3.
REQ-014 SHALL have port fifo_level  output  clog2(FIFO_DEPTH)+1  frames stored.

Function
REQ-015 SHALL push a frame when in_valid && in_ready; a simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-016 SHALL use layout 0 when CHANNEL_COUNT==2: each packet pops min(fifo_level,4) frames, one frame per subpacket, in order 0..3.
REQ-017 SHALL use layout 1 when CHANNEL_COUNT>2: each packet pops exactly one frame; subpacket i carries channels 2i (left half) and 2i+1 (right half).
REQ-018 SHALL, on pkt_request with fifo_level>0, assert pkt_valid for exactly one cycle, the cycle after the request, with header and sub registered and stable that cycle.
REQ-019 SHALL ignore pkt_request when fifo_level==0: no pop, pkt_valid stays 0.
REQ-020 SHALL ignore pkt_request arriving while pkt_valid=1.
REQ-021 SHALL set HB0=8'h02, HB1={3'b000, layout, sample_present[3:0]} and HB2={B[3:0], 4'b0000}.
REQ-022 SHALL drive unused subpackets and their sample_present bits to 0.
REQ-023 SHALL keep an 8-bit frame counter that advances once per popped frame and wraps 191->0.
REQ-024 SHALL assign frame k of a layout-0 packet the counter value base+k (mod 192).
REQ-025 SHALL set B[k]=1 iff that frame's counter value is 0; in layout 1 only B[0] is used.
REQ-026 SHALL give each subpacket the format {P_R,C_R,U_R,V_R,P_L,C_L,U_L,V_L, word_R[23:0], word_L[23:0]}, with V=U=0.
REQ-027 SHALL take C as channel-status bit [frame counter] of the 192-bit status word whose channel-number field is channel index + 1.
REQ-028 SHALL make each P even parity over {C,U,V,word}.
REQ-029 SHALL keep in_ready = (fifo_level < FIFO_DEPTH); a push when full is impossible by construction.

Reset
REQ-030 SHALL, while reset_n=0, immediately clear the FIFO pointers, fifo_level, frame counter, pkt_valid, header and sub to 0 and hold in_ready=0.
REQ-031 SHALL raise in_ready in the first clk_pixel edge after reset_n deasserts.
REQ-032 SHALL, when reset asserts mid-packet, drop the packet with no partial output.

Structure
REQ-033 SHALL place the header type constant (8'h02), the channel-status 192-bit builder function and the parity function in package audio_pkg.
REQ-034 SHALL implement buffering in one sub-module audio_sample_fifo (synchronous, width CHANNEL_COUNT*SAMPLE_WIDTH, first-word-fall-through with 4-entry lookahead read for layout 0).

Verification
REQ-035 SHALL verify stereo case: 2 frames (L=16'h1234, R=16'hABCD) then pkt_request -> HB1=8'h03, HB2=8'h10, sub0[47:0]=48'hABCD00_123400, fifo_level 0.
REQ-036 SHALL verify wrap: 193 frames popped -> frame at counter 191 has B=0; the next has B=1 and C equals status bit 0.
REQ-037 SHALL verify 8-channel case, FIFO_DEPTH=4: 5 pushes with no requests -> in_ready low after 4 and the 5th held until a pop; each packet has HB1=8'h1F.
REQ-038 SHALL verify empty: pkt_request with fifo_level 0 -> pkt_valid stays 0 and the counter is unchanged.
REQ-039 SHALL verify simultaneous events: push and pkt_request on the same cycle at level 1 (stereo) -> the packet holds 1 frame and the new frame remains, level 1.
REQ-040 SHALL verify reset: reset_n low during the pkt_valid cycle -> all outputs 0 in the same cycle; after release, level 0 and counter 0.
